// File: rtl/i2c_seq_pkg.sv
// Shared constants and types for the I2C master-core WISHBONE sequencer.
package i2c_seq_pkg;

   // Core register map
   localparam logic [2:0] REG_PRERLO  = 3'd0;
   localparam logic [2:0] REG_PRERHI  = 3'd1;
   localparam logic [2:0] REG_CTR     = 3'd2;
   localparam logic [2:0] REG_TXR_RXR = 3'd3;
   localparam logic [2:0] REG_CR_SR   = 3'd4;

   // Command register bits
   localparam int CR_STA  = 7;
   localparam int CR_STO  = 6;
   localparam int CR_RD   = 5;
   localparam int CR_WR   = 4;
   localparam int CR_ACK  = 3;
   localparam int CR_IACK = 0;

   // Status register bits
   localparam int SR_RXACK = 7;
   localparam int SR_BUSY  = 6;
   localparam int SR_AL    = 5;
   localparam int SR_TIP   = 1;
   localparam int SR_IF    = 0;

   // Control register: core enabled, interrupt disabled
   localparam logic [7:0] CTR_INIT = 8'h80;

   typedef enum logic [3:0] {
      S_INIT_LO, S_INIT_HI, S_INIT_CTR, S_IDLE,
      S_ADDR_TXR, S_ADDR_CR, S_POLL,
      S_WR_WAIT, S_WR_TXR, S_WR_CR,
      S_RD_CR, S_RD_RXR, S_RD_OUT, S_STOP
   } state_e;

   typedef enum logic [1:0] {
      STAT_OK       = 2'b00,
      STAT_NACK     = 2'b01,
      STAT_ARB_LOST = 2'b10,
      STAT_TIMEOUT  = 2'b11
   } status_e;

   // Which command the current SR poll is waiting on
   typedef enum logic [1:0] {PH_ADDR, PH_WR, PH_RD, PH_STOP} phase_e;

   // Single-bit mask for a CR/SR bit position
   function automatic logic [7:0] bit8(input int n);
      return 8'h01 << n;
   endfunction

endpackage

// File: rtl/i2c_seq_wb_xfer.sv
// Single-access WISHBONE master engine: one start pulse -> one registered
// bus cycle held until ack, read data captured on ack, fin pulses once.
module i2c_seq_wb_xfer (
   input  logic       wb_clk_i,
   input  logic       arst_i,
   input  logic       start,
   input  logic       we,
   input  logic [2:0] adr,
   input  logic [7:0] wdat,
   output logic       busy,
   output logic [7:0] rdat,
   output logic       fin,
   output logic [2:0] wbm_adr_o,
   output logic [7:0] wbm_dat_o,
   input  logic [7:0] wbm_dat_i,
   output logic       wbm_we_o,
   output logic       wbm_stb_o,
   output logic       wbm_cyc_o,
   input  logic       wbm_ack_i
);

   logic       cyc_reg;
   logic       we_reg;
   logic [2:0] adr_reg;
   logic [7:0] dat_reg;
   logic [7:0] rdat_reg;
   logic       fin_reg;

   // Launch on start, hold everything until ack, then release the bus for at least a cycle
   always_ff @(posedge wb_clk_i or posedge arst_i) begin
      if (arst_i) begin
         cyc_reg  <= 1'b0;
         we_reg   <= 1'b0;
         adr_reg  <= '0;
         dat_reg  <= '0;
         rdat_reg <= '0;
         fin_reg  <= 1'b0;
      end else begin
         fin_reg <= 1'b0;
         if (cyc_reg) begin
            if (wbm_ack_i) begin
               cyc_reg  <= 1'b0;
               we_reg   <= 1'b0;
               adr_reg  <= '0;
               dat_reg  <= '0;
               rdat_reg <= wbm_dat_i;
               fin_reg  <= 1'b1;
            end
         end else if (start) begin
            cyc_reg <= 1'b1;
            we_reg  <= we;
            adr_reg <= adr;
            dat_reg <= we ? wdat : 8'h00;
         end
      end
   end

   assign busy      = cyc_reg;
   assign rdat      = rdat_reg;
   assign fin       = fin_reg;
   assign wbm_cyc_o = cyc_reg;
   assign wbm_stb_o = cyc_reg;
   assign wbm_we_o  = we_reg;
   assign wbm_adr_o = adr_reg;
   assign wbm_dat_o = dat_reg;

endmodule

// File: rtl/i2c_wb_sequencer.sv
// Turns a (slave address, direction, length) request into the I2C master
// core's register-access sequence, streaming bytes over valid/ready.
module i2c_wb_sequencer
   import i2c_seq_pkg::*;
#(
   parameter logic [15:0] PRESCALE     = 16'd99,
   parameter int          MAX_LEN      = 16,
   parameter logic [15:0] POLL_TIMEOUT = 16'hFFFF,
   localparam int         LW           = $clog2(MAX_LEN + 1)
) (
   input  logic          wb_clk_i,
   input  logic          arst_i,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [6:0]    req_addr,
   input  logic          req_rnw,
   input  logic [LW-1:0] req_len,
   input  logic [7:0]    wr_data,
   input  logic          wr_valid,
   output logic          wr_ready,
   output logic [7:0]    rd_data,
   output logic          rd_valid,
   input  logic          rd_ready,
   output logic          done,
   output logic [1:0]    status,
   output logic [2:0]    wbm_adr_o,
   output logic [7:0]    wbm_dat_o,
   input  logic [7:0]    wbm_dat_i,
   output logic          wbm_we_o,
   output logic          wbm_stb_o,
   output logic          wbm_cyc_o,
   input  logic          wbm_ack_i
);

   state_e        state_reg;
   phase_e        phase_reg;
   status_e       status_reg, stop_status_reg;
   logic          pend_reg, start_reg;
   logic [6:0]    addr_reg;
   logic          rnw_reg;
   logic [LW-1:0] cnt_reg;
   logic [7:0]    data_reg, rd_data_reg;
   logic [15:0]   poll_cnt_reg;
   logic          req_ready_reg, wr_ready_reg, rd_valid_reg, done_reg;

   logic          acc_req, acc_we;
   logic [2:0]    acc_adr;
   logic [7:0]    acc_wdat;
   logic          x_busy, x_fin;
   logic [7:0]    x_rdat;
   logic          poll_finish;
   status_e       poll_stat;
   state_e        poll_next;

   i2c_seq_wb_xfer u_xfer (
      .wb_clk_i (wb_clk_i),  .arst_i (arst_i),
      .start    (start_reg), .we     (acc_we),   .adr (acc_adr), .wdat (acc_wdat),
      .busy     (x_busy),    .rdat   (x_rdat),   .fin (x_fin),
      .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
      .wbm_we_o (wbm_we_o),  .wbm_stb_o(wbm_stb_o), .wbm_cyc_o(wbm_cyc_o),
      .wbm_ack_i(wbm_ack_i)
   );

   // Register access implied by each state (held stable while the access is pending)
   always_comb begin
      acc_req  = 1'b1;
      acc_we   = 1'b1;
      acc_adr  = REG_CR_SR;
      acc_wdat = 8'h00;
      case (state_reg)
         S_INIT_LO:  begin acc_adr = REG_PRERLO;  acc_wdat = PRESCALE[7:0];  end
         S_INIT_HI:  begin acc_adr = REG_PRERHI;  acc_wdat = PRESCALE[15:8]; end
         S_INIT_CTR: begin acc_adr = REG_CTR;     acc_wdat = CTR_INIT;       end
         S_ADDR_TXR: begin acc_adr = REG_TXR_RXR; acc_wdat = {addr_reg, rnw_reg}; end
         S_ADDR_CR:  acc_wdat = bit8(CR_STA) | bit8(CR_WR) | ((cnt_reg == '0) ? bit8(CR_STO) : 8'h00);
         S_POLL:     acc_we   = 1'b0;
         S_WR_TXR:   begin acc_adr = REG_TXR_RXR; acc_wdat = data_reg; end
         S_WR_CR:    acc_wdat = bit8(CR_WR) | ((cnt_reg == LW'(1)) ? bit8(CR_STO) : 8'h00);
         S_RD_CR:    acc_wdat = bit8(CR_RD) |
                                ((cnt_reg == LW'(1)) ? (bit8(CR_ACK) | bit8(CR_STO)) : 8'h00);
         S_RD_RXR:   begin acc_we = 1'b0; acc_adr = REG_TXR_RXR; end
         S_STOP:     acc_wdat = bit8(CR_STO);
         default:    acc_req  = 1'b0;
      endcase
   end

   // Decision taken when an SR read completes; a NACK on a command that already carried STO ends directly
   always_comb begin
      poll_finish = 1'b0;
      poll_stat   = STAT_OK;
      poll_next   = S_POLL;
      if (x_rdat[SR_AL]) begin
         poll_finish = 1'b1;
         poll_stat   = STAT_ARB_LOST;
      end else if (x_rdat[SR_TIP]) begin
         if (poll_cnt_reg == POLL_TIMEOUT - 16'd1) begin
            poll_next = S_STOP;
            poll_stat = STAT_TIMEOUT;
         end
      end else begin
         case (phase_reg)
            PH_ADDR, PH_WR: begin
               if (x_rdat[SR_RXACK]) begin
                  poll_stat = STAT_NACK;
                  if (cnt_reg == '0) poll_finish = 1'b1;
                  else               poll_next   = S_STOP;
               end else if (cnt_reg == '0) poll_finish = 1'b1;
               else if (phase_reg == PH_ADDR && rnw_reg) poll_next = S_RD_CR;
               else poll_next = S_WR_WAIT;
            end
            PH_RD:   poll_next = S_RD_RXR;
            default: begin
               poll_finish = 1'b1;
               poll_stat   = stop_status_reg;
            end
         endcase
      end
   end

   // Main sequencer FSM with registered handshake and status outputs
   always_ff @(posedge wb_clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_reg       <= S_INIT_LO;
         phase_reg       <= PH_ADDR;
         status_reg      <= STAT_OK;
         stop_status_reg <= STAT_OK;
         pend_reg        <= 1'b0;
         start_reg       <= 1'b0;
         addr_reg        <= '0;
         rnw_reg         <= 1'b0;
         cnt_reg         <= '0;
         data_reg        <= '0;
         rd_data_reg     <= '0;
         poll_cnt_reg    <= '0;
         req_ready_reg   <= 1'b0;
         wr_ready_reg    <= 1'b0;
         rd_valid_reg    <= 1'b0;
         done_reg        <= 1'b0;
      end else begin
         start_reg    <= 1'b0;
         done_reg     <= 1'b0;
         wr_ready_reg <= 1'b0;
         if (state_reg != S_POLL) poll_cnt_reg <= '0;
         if (acc_req && !pend_reg && !x_busy) begin
            start_reg <= 1'b1;
            pend_reg  <= 1'b1;
         end
         if (x_fin) pend_reg <= 1'b0;

         case (state_reg)
            S_INIT_LO:  if (x_fin) state_reg <= S_INIT_HI;
            S_INIT_HI:  if (x_fin) state_reg <= S_INIT_CTR;
            S_INIT_CTR: if (x_fin) begin
               state_reg     <= S_IDLE;
               req_ready_reg <= 1'b1;
            end
            S_IDLE: if (req_valid) begin
               addr_reg      <= req_addr;
               rnw_reg       <= req_rnw;
               cnt_reg       <= (req_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : req_len;
               phase_reg     <= PH_ADDR;
               req_ready_reg <= 1'b0;
               state_reg     <= S_ADDR_TXR;
            end
            S_ADDR_TXR: if (x_fin) state_reg <= S_ADDR_CR;
            S_ADDR_CR:  if (x_fin) state_reg <= S_POLL;
            S_POLL: if (x_fin) begin
               if (poll_finish) begin
                  done_reg      <= 1'b1;
                  status_reg    <= poll_stat;
                  req_ready_reg <= 1'b1;
                  state_reg     <= S_IDLE;
               end else begin
                  state_reg       <= poll_next;
                  stop_status_reg <= poll_stat;
                  if (poll_next == S_POLL) poll_cnt_reg <= poll_cnt_reg + 16'd1;
               end
            end
            S_WR_WAIT: if (wr_valid) begin
               data_reg     <= wr_data;
               wr_ready_reg <= 1'b1;
               state_reg    <= S_WR_TXR;
            end
            S_WR_TXR: if (x_fin) state_reg <= S_WR_CR;
            S_WR_CR, S_RD_CR: if (x_fin) begin
               cnt_reg   <= cnt_reg - LW'(1);
               phase_reg <= (state_reg == S_WR_CR) ? PH_WR : PH_RD;
               state_reg <= S_POLL;
            end
            S_RD_RXR: if (x_fin) begin
               rd_data_reg  <= x_rdat;
               rd_valid_reg <= 1'b1;
               state_reg    <= S_RD_OUT;
            end
            S_RD_OUT: if (rd_ready) begin
               rd_valid_reg <= 1'b0;
               if (cnt_reg == '0) begin
                  done_reg      <= 1'b1;
                  status_reg    <= STAT_OK;
                  req_ready_reg <= 1'b1;
                  state_reg     <= S_IDLE;
               end else begin
                  state_reg <= S_RD_CR;
               end
            end
            S_STOP: if (x_fin) begin
               if (stop_status_reg == STAT_TIMEOUT) begin
                  done_reg      <= 1'b1;
                  status_reg    <= STAT_TIMEOUT;
                  req_ready_reg <= 1'b1;
                  state_reg     <= S_IDLE;
               end else begin
                  phase_reg <= PH_STOP;
                  state_reg <= S_POLL;
               end
            end
            default: state_reg <= S_INIT_LO;
         endcase
      end
   end

   assign req_ready = req_ready_reg;
   assign wr_ready  = wr_ready_reg;
   assign rd_data   = rd_data_reg;
   assign rd_valid  = rd_valid_reg;
   assign done      = done_reg;
   assign status    = status_reg;

endmodule

// File: tb/tb_i2c_wb_sequencer.sv
// Scoreboard bench: tests push expected WB accesses, read bytes and done
// statuses; monitors pop and compare as the DUT presents them.
module tb_i2c_wb_sequencer;

   localparam int LW = 5;

   logic          wb_clk_i = 1'b0;
   logic          arst_i   = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [6:0]    req_addr = '0;
   logic          req_rnw  = 1'b0;
   logic [LW-1:0] req_len  = '0;
   logic [7:0]    wr_data  = '0;
   logic          wr_valid = 1'b0;
   logic          wr_ready;
   logic [7:0]    rd_data;
   logic          rd_valid;
   logic          rd_ready = 1'b0;
   logic          done;
   logic [1:0]    status;
   logic [2:0]    wbm_adr_o;
   logic [7:0]    wbm_dat_o;
   logic [7:0]    wbm_dat_i = '0;
   logic          wbm_we_o, wbm_stb_o, wbm_cyc_o;
   logic          wbm_ack_i = 1'b0;

   i2c_wb_sequencer dut (
      .wb_clk_i(wb_clk_i), .arst_i(arst_i),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_rnw(req_rnw), .req_len(req_len),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .done(done), .status(status),
      .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
      .wbm_we_o(wbm_we_o), .wbm_stb_o(wbm_stb_o), .wbm_cyc_o(wbm_cyc_o),
      .wbm_ack_i(wbm_ack_i)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   int checks = 0, failures = 0;
   logic [11:0] exp_wb[$];
   logic [7:0]  exp_rd[$];
   logic [1:0]  exp_done[$];
   logic [7:0]  sr_q[$], rx_q[$], wr_q[$];
   bit          wb_check_en = 1'b1;
   int          wr_seen = 0, rd_beats = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   function automatic void pw(input logic [2:0] a, input logic [7:0] d);
      exp_wb.push_back({1'b1, a, d});
   endfunction

   function automatic void pr(input logic [2:0] a);
      exp_wb.push_back({1'b0, a, 8'h00});
   endfunction

   // Slave register port: ack one cycle after strobe, SR/RXR values from scripts
   always @(posedge wb_clk_i) begin
      if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i) begin
         wbm_ack_i <= 1'b1;
         if (!wbm_we_o && wbm_adr_o == 3'd4) begin
            if (sr_q.size() > 0) wbm_dat_i <= sr_q.pop_front();
            else                 wbm_dat_i <= 8'h00;
         end else if (!wbm_we_o && wbm_adr_o == 3'd3) begin
            if (rx_q.size() > 0) wbm_dat_i <= rx_q.pop_front();
            else                 wbm_dat_i <= 8'h00;
         end else wbm_dat_i <= 8'h00;
      end else begin
         wbm_ack_i <= 1'b0;
      end
   end

   // WB access monitor
   always @(negedge wb_clk_i) begin
      if (wbm_cyc_o && wbm_stb_o && wbm_ack_i && wb_check_en) begin
         logic [11:0] obs;
         obs = {wbm_we_o, wbm_adr_o, wbm_we_o ? wbm_dat_o : 8'h00};
         $display("wb %s adr=%0d dat=%02h", wbm_we_o ? "W" : "R", wbm_adr_o, obs[7:0]);
         if (exp_wb.size() == 0) chk("wb_extra", int'(obs), -1);
         else                    chk("wb_access", int'(obs), int'(exp_wb.pop_front()));
      end
      if (wr_ready) wr_seen++;
   end

   // Done/status monitor
   always @(negedge wb_clk_i) begin
      if (done) begin
         $display("done status=%0d", status);
         if (exp_done.size() == 0) chk("done_extra", int'(status), -1);
         else                      chk("done_status", int'(status), int'(exp_done.pop_front()));
      end
   end

   // Read-byte consumer: check byte, then accept it for one cycle
   initial begin
      forever begin
         @(negedge wb_clk_i);
         if (rd_ready) rd_ready = 1'b0;
         else if (rd_valid) begin
            $display("rd data=%02h", rd_data);
            rd_beats++;
            if (exp_rd.size() == 0) chk("rd_extra", int'(rd_data), -1);
            else                    chk("rd_data", int'(rd_data), int'(exp_rd.pop_front()));
            rd_ready = 1'b1;
         end
      end
   end

   // Write-byte producer: hold valid until wr_ready is seen
   initial begin
      forever begin
         @(negedge wb_clk_i);
         if (wr_valid && wr_ready) begin
            void'(wr_q.pop_front());
            wr_valid = 1'b0;
         end else if (!wr_valid && wr_q.size() > 0) begin
            wr_data  = wr_q[0];
            wr_valid = 1'b1;
         end
      end
   end

   task automatic wait_drain(input string name);
      int n = 0;
      while ((exp_wb.size() != 0 || exp_done.size() != 0 || exp_rd.size() != 0) && n < 3000) begin
         @(negedge wb_clk_i);
         n++;
      end
      chk({"drain_", name}, int'(n < 3000), 1);
      repeat (4) @(negedge wb_clk_i);
   endtask

   task automatic do_req(input logic [6:0] a, input logic rnw, input int len);
      int n = 0;
      while (!req_ready && n < 1000) begin
         @(negedge wb_clk_i);
         n++;
      end
      chk("req_ready_high", int'(req_ready), 1);
      req_addr  = a;
      req_rnw   = rnw;
      req_len   = LW'(len);
      req_valid = 1'b1;
      @(negedge wb_clk_i);
      req_valid = 1'b0;
      chk("req_ready_drop", int'(req_ready), 0);
   endtask

   initial begin
      // Reset state, then INIT sequence
      repeat (3) @(negedge wb_clk_i);
      chk("rst_cyc", int'(wbm_cyc_o), 0);
      chk("rst_req_ready", int'(req_ready), 0);
      chk("rst_done", int'(done), 0);
      pw(3'd0, 8'h63); pw(3'd1, 8'h00); pw(3'd2, 8'h80);
      arst_i = 1'b0;
      wait_drain("init");
      chk("init_req_ready", int'(req_ready), 1);

      // Write 2 bytes to 0x50, one extra TIP poll on the address phase
      sr_q = '{8'h02, 8'h00};
      wr_q = '{8'hA5, 8'h3C};
      pw(3'd3, 8'hA0); pw(3'd4, 8'h90); pr(3'd4); pr(3'd4);
      pw(3'd3, 8'hA5); pw(3'd4, 8'h10); pr(3'd4);
      pw(3'd3, 8'h3C); pw(3'd4, 8'h50); pr(3'd4);
      exp_done.push_back(2'b00);
      do_req(7'h50, 1'b0, 2);
      wait_drain("write2");
      chk("write2_wr_pulses", wr_seen, 2);

      // Read 2 bytes from 0x50
      rx_q = '{8'h11, 8'h22};
      pw(3'd3, 8'hA1); pw(3'd4, 8'h90); pr(3'd4);
      pw(3'd4, 8'h20); pr(3'd4); pr(3'd3);
      pw(3'd4, 8'h68); pr(3'd4); pr(3'd3);
      exp_rd.push_back(8'h11); exp_rd.push_back(8'h22);
      exp_done.push_back(2'b00);
      do_req(7'h50, 1'b1, 2);
      wait_drain("read2");

      // Address NACK on a write: STO then done NACK, no data handshakes
      sr_q = '{8'h80};
      pw(3'd3, 8'hA0); pw(3'd4, 8'h90); pr(3'd4); pw(3'd4, 8'h40); pr(3'd4);
      exp_done.push_back(2'b01);
      do_req(7'h50, 1'b0, 1);
      wait_drain("nack");
      chk("nack_wr_pulses", wr_seen, 2);
      chk("nack_rd_beats", rd_beats, 2);

      // Arbitration lost during poll: no STO
      sr_q = '{8'h22};
      pw(3'd3, 8'hA1); pw(3'd4, 8'h90); pr(3'd4);
      exp_done.push_back(2'b10);
      do_req(7'h50, 1'b1, 1);
      wait_drain("arb_lost");

      // Zero-length probe, ACK then NACK
      pw(3'd3, 8'h78); pw(3'd4, 8'hD0); pr(3'd4);
      exp_done.push_back(2'b00);
      do_req(7'h3C, 1'b0, 0);
      wait_drain("probe_ack");
      sr_q = '{8'h80};
      pw(3'd3, 8'h78); pw(3'd4, 8'hD0); pr(3'd4);
      exp_done.push_back(2'b01);
      do_req(7'h3C, 1'b0, 0);
      wait_drain("probe_nack");

      // Single write with late data: FSM stalls in WR_WAIT without wr_ready
      pw(3'd3, 8'h42); pw(3'd4, 8'h90); pr(3'd4);
      pw(3'd3, 8'h7E); pw(3'd4, 8'h50); pr(3'd4);
      exp_done.push_back(2'b00);
      do_req(7'h21, 1'b0, 1);
      repeat (30) @(negedge wb_clk_i);
      chk("stall_no_wr_ready", wr_seen, 2);
      wr_q.push_back(8'h7E);
      wait_drain("late_write");
      chk("late_wr_pulses", wr_seen, 3);

      // Reset during the first SR poll of a read: bus drops at once, INIT replays, no done
      begin
         int n = 0;
         wb_check_en = 1'b0;
         sr_q = '{8'h02, 8'h02, 8'h02};
         do_req(7'h50, 1'b1, 1);
         while (!(wbm_stb_o && !wbm_we_o && wbm_adr_o == 3'd4) && n < 200) begin
            @(negedge wb_clk_i);
            n++;
         end
         chk("abort_found_poll", int'(n < 200), 1);
         arst_i = 1'b1;
         #1;
         chk("abort_stb_low", int'(wbm_stb_o), 0);
         chk("abort_cyc_low", int'(wbm_cyc_o), 0);
         repeat (2) @(negedge wb_clk_i);
         sr_q.delete();
         rx_q.delete();
         pw(3'd0, 8'h63); pw(3'd1, 8'h00); pw(3'd2, 8'h80);
         wb_check_en = 1'b1;
         arst_i = 1'b0;
         wait_drain("reinit");
         chk("reinit_req_ready", int'(req_ready), 1);
         chk("abort_rd_beats", rd_beats, 2);
      end

      chk("left_exp_wb", exp_wb.size(), 0);
      chk("left_exp_done", exp_done.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
